// File: rtl/cmem_arb.sv
// cmem_arb: round-robin line-fill arbiter onto one external read port, plus
// write-invalidate broadcast with taint re-fetch (built only with CMEM_ARB_INV_EN).
module cmem_arb #(
  parameter int N_REQ   = 2,
  parameter int BLK_LEN = 58,
  parameter int LINE    = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*BLK_LEN-1:0] r_addr,
  input  logic [N_REQ-1:0]         r_rd,
  output logic [LINE-1:0]          r_rdata,
  output logic [N_REQ-1:0]         r_dv,
  output logic [BLK_LEN-1:0]       m_addr,
  output logic                     m_rd,
  input  logic [LINE-1:0]          m_rdata,
  input  logic                     m_dv,
  input  logic [N_REQ*BLK_LEN-1:0] w_addr,
  input  logic [N_REQ-1:0]         w_wr,
  output logic [N_REQ-1:0]         w_stall,
  output logic [BLK_LEN-1:0]       inv_addr,
  output logic [N_REQ-1:0]         inv,
  output logic [N_REQ-1:0]         grant
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, RESP, GAP} state_t;

  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0] start);
    int j;
    logic found;
    rr_pick = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(start) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        rr_pick = IW'(j);
      end
    end
  endfunction

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] x);
    return (x == IW'(N_REQ - 1)) ? '0 : x + IW'(1);
  endfunction

  state_t             state, state_nx;
  logic [IW-1:0]      g, ptr, pick;
  logic [BLK_LEN-1:0] a;
  logic               refetch, refetch_nx;
  logic               taint_hit;

  assign pick   = rr_pick(r_rd, ptr);
  assign m_addr = a;

  always_comb begin
    state_nx   = state;
    refetch_nx = refetch;
    m_rd       = 1'b0;
    grant      = '0;
    r_dv       = '0;
    case (state)
      IDLE: if (|r_rd) state_nx = FETCH;
      FETCH: begin
        m_rd     = 1'b1;
        grant[g] = 1'b1;
        if (m_dv) begin
          // A tainted line is discarded and fetched again after one idle cycle.
          if (taint_hit) begin
            state_nx   = GAP;
            refetch_nx = 1'b1;
          end else begin
            state_nx = RESP;
          end
        end
      end
      RESP: begin
        r_dv[g]  = 1'b1;
        grant[g] = 1'b1;
        state_nx = GAP;
      end
      default: begin
        state_nx   = refetch ? FETCH : IDLE;
        refetch_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      g       <= '0;
      a       <= '0;
      ptr     <= '0;
      refetch <= 1'b0;
      r_rdata <= '0;
    end else begin
      state   <= state_nx;
      refetch <= refetch_nx;
      if (state == IDLE && |r_rd) begin
        g <= pick;
        a <= r_addr[pick*BLK_LEN +: BLK_LEN];
      end
      if (state == FETCH && m_dv) r_rdata <= m_rdata;
      if (state == RESP) ptr <= inc(g);
    end
  end

`ifdef CMEM_ARB_INV_EN
  logic [N_REQ-1:0]   sv, sv_nx, drain, drain_nx, load;
  logic [BLK_LEN-1:0] sa [N_REQ];
  logic [IW-1:0]      iptr, iptr_nx, di;
  logic               taint, hit;

  always_comb begin
    di       = rr_pick(sv, iptr);
    drain    = '0;
    inv      = '0;
    inv_addr = '0;
    if (|sv) begin
      drain[di] = 1'b1;
      inv       = ~drain;
      inv_addr  = sa[di];
    end
    load     = w_wr & (~sv | drain);
    sv_nx    = (sv & ~drain) | load;
    iptr_nx  = (|sv) ? inc(di) : iptr;
    // Stall is registered, so look ahead at which slot drains next cycle.
    drain_nx = '0;
    if (|sv_nx) drain_nx[rr_pick(sv_nx, iptr_nx)] = 1'b1;
    hit = (state == FETCH) && (|sv) && (inv_addr == a) && inv[g];
  end

  assign taint_hit = taint | hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sv      <= '0;
      iptr    <= '0;
      taint   <= 1'b0;
      w_stall <= '0;
      for (int i = 0; i < N_REQ; i++) sa[i] <= '0;
    end else begin
      sv      <= sv_nx;
      iptr    <= iptr_nx;
      w_stall <= sv_nx & ~drain_nx;
      for (int i = 0; i < N_REQ; i++)
        if (load[i]) sa[i] <= w_addr[i*BLK_LEN +: BLK_LEN];
      if (state == FETCH) taint <= m_dv ? 1'b0 : taint_hit;
    end
  end
`else
  logic unused_w;
  assign unused_w  = ^{w_addr, w_wr};
  assign taint_hit = 1'b0;
  assign inv       = '0;
  assign inv_addr  = '0;
  assign w_stall   = '0;
`endif

endmodule

// File: tb/tb_cmem_arb.sv
// Directed bench for cmem_arb; expected invalidation results follow CMEM_ARB_INV_EN.
module tb_cmem_arb;
  localparam int N  = 2;
  localparam int BL = 58;
  localparam int LN = 512;
`ifdef CMEM_ARB_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic            clk, rst;
  logic [N*BL-1:0] r_addr, w_addr;
  logic [N-1:0]    r_rd, r_dv, w_wr, w_stall, inv, grant;
  logic [LN-1:0]   r_rdata, m_rdata;
  logic [BL-1:0]   m_addr, inv_addr;
  logic            m_rd, m_dv;
  int              pass_cnt, total;

  cmem_arb #(.N_REQ(N), .BLK_LEN(BL), .LINE(LN)) dut (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_rd(r_rd), .r_rdata(r_rdata),
    .r_dv(r_dv), .m_addr(m_addr), .m_rd(m_rd), .m_rdata(m_rdata), .m_dv(m_dv),
    .w_addr(w_addr), .w_wr(w_wr), .w_stall(w_stall), .inv_addr(inv_addr),
    .inv(inv), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; r_addr = '0; r_rd = '0; m_rdata = '0; m_dv = 1'b0;
    w_addr = '0; w_wr = '0;
    tick; tick;
    total++; if (m_rd !== 1'b0) $display("FAIL rst_m_rd got %b want 0", m_rd); else pass_cnt++;
    total++; if (m_addr !== '0) $display("FAIL rst_m_addr got %h want 0", m_addr); else pass_cnt++;
    total++; if (r_dv !== 2'b00) $display("FAIL rst_r_dv got %b want 00", r_dv); else pass_cnt++;
    total++; if (r_rdata !== '0) $display("FAIL rst_r_rdata got %h want 0", r_rdata); else pass_cnt++;
    total++; if (grant !== 2'b00) $display("FAIL rst_grant got %b want 00", grant); else pass_cnt++;
    total++; if (inv !== 2'b00) $display("FAIL rst_inv got %b want 00", inv); else pass_cnt++;
    total++; if (inv_addr !== '0) $display("FAIL rst_inv_addr got %h want 0", inv_addr); else pass_cnt++;
    total++; if (w_stall !== 2'b00) $display("FAIL rst_w_stall got %b want 00", w_stall); else pass_cnt++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_single_fill;
    logic [LN-1:0] d;
    d = {16{32'h1234_ABCD}};
    r_addr[0 +: BL] = 58'h100;
    r_rd = 2'b01;
    tick;
    total++; if (m_rd !== 1'b1) $display("FAIL fill_m_rd got %b want 1", m_rd); else pass_cnt++;
    total++; if (m_addr !== 58'h100) $display("FAIL fill_m_addr got %h want 100", m_addr); else pass_cnt++;
    total++; if (grant !== 2'b01) $display("FAIL fill_grant got %b want 01", grant); else pass_cnt++;
    tick; tick; tick; tick;
    total++; if (r_dv !== 2'b00) $display("FAIL fill_early_r_dv got %b want 00", r_dv); else pass_cnt++;
    tick;
    m_dv = 1'b1; m_rdata = d;
    tick;
    m_dv = 1'b0; m_rdata = '0;
    total++; if (r_dv !== 2'b01) $display("FAIL fill_r_dv got %b want 01", r_dv); else pass_cnt++;
    total++; if (r_rdata !== d) $display("FAIL fill_r_rdata got %h want %h", r_rdata, d); else pass_cnt++;
    r_rd = 2'b00;
    tick;
    total++; if (m_rd !== 1'b0) $display("FAIL fill_gap_m_rd got %b want 0", m_rd); else pass_cnt++;
    total++; if (r_rdata !== d) $display("FAIL fill_hold_rdata got %h want %h", r_rdata, d); else pass_cnt++;
  endtask

  // Starts in the GAP cycle after the single fill, so ptr must already point at core 1.
  task automatic test_contention;
    logic [LN-1:0] d;
    logic [N-1:0]  exp_oh;
    logic [BL-1:0] exp_a;
    int            n;
    r_addr[0 +: BL]  = 58'h200;
    r_addr[BL +: BL] = 58'h300;
    r_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b10 : 2'b01;
      exp_a  = (k % 2 == 0) ? 58'h300 : 58'h200;
      d = {16{32'hC0DE_0000 + 32'(k)}};
      n = 0;
      while (m_rd !== 1'b1 && n < 8) begin
        tick;
        n++;
      end
      total++; if (n != 2) $display("FAIL cont_latency_%0d got %0d want 2", k, n); else pass_cnt++;
      total++; if (grant !== exp_oh) $display("FAIL cont_grant_%0d got %b want %b", k, grant, exp_oh); else pass_cnt++;
      total++; if (m_addr !== exp_a) $display("FAIL cont_m_addr_%0d got %h want %h", k, m_addr, exp_a); else pass_cnt++;
      m_dv = 1'b1; m_rdata = d;
      tick;
      m_dv = 1'b0; m_rdata = '0;
      total++; if (r_dv !== exp_oh) $display("FAIL cont_r_dv_%0d got %b want %b", k, r_dv, exp_oh); else pass_cnt++;
      total++; if (r_rdata !== d) $display("FAIL cont_r_rdata_%0d got %h want %h", k, r_rdata, d); else pass_cnt++;
      r_rd = r_rd & ~exp_oh;
      tick;
      total++; if (m_rd !== 1'b0) $display("FAIL cont_gap_m_rd_%0d got %b want 0", k, m_rd); else pass_cnt++;
      r_rd = (k == 3) ? 2'b00 : 2'b11;
    end
    tick;
  endtask

  // Entered with iptr at 0 (nothing drained yet).
  task automatic test_invalidate;
    logic [N-1:0]  e_inv, e_st;
    logic [BL-1:0] e_a;
    w_addr[0 +: BL] = 58'h2A; w_addr[BL +: BL] = 58'h3B; w_wr = 2'b11;
    tick;
    w_wr = 2'b00;
    e_inv = INV_ON ? 2'b10 : 2'b00; e_a = INV_ON ? 58'h2A : 58'h0; e_st = INV_ON ? 2'b10 : 2'b00;
    total++; if (inv !== e_inv) $display("FAIL inv_pair0 got %b want %b", inv, e_inv); else pass_cnt++;
    total++; if (inv_addr !== e_a) $display("FAIL inv_pair0_addr got %h want %h", inv_addr, e_a); else pass_cnt++;
    total++; if (w_stall !== e_st) $display("FAIL inv_pair0_stall got %b want %b", w_stall, e_st); else pass_cnt++;
    tick;
    e_inv = INV_ON ? 2'b01 : 2'b00; e_a = INV_ON ? 58'h3B : 58'h0;
    total++; if (inv !== e_inv) $display("FAIL inv_pair1 got %b want %b", inv, e_inv); else pass_cnt++;
    total++; if (inv_addr !== e_a) $display("FAIL inv_pair1_addr got %h want %h", inv_addr, e_a); else pass_cnt++;
    tick;
    total++; if (inv !== 2'b00) $display("FAIL inv_pair_done got %b want 00", inv); else pass_cnt++;
    w_addr[0 +: BL] = 58'h55; w_wr = 2'b01;
    tick;
    w_wr = 2'b00;
    e_inv = INV_ON ? 2'b10 : 2'b00; e_a = INV_ON ? 58'h55 : 58'h0;
    total++; if (inv !== e_inv) $display("FAIL inv_single got %b want %b", inv, e_inv); else pass_cnt++;
    total++; if (inv_addr !== e_a) $display("FAIL inv_single_addr got %h want %h", inv_addr, e_a); else pass_cnt++;
    total++; if (w_stall !== 2'b00) $display("FAIL inv_single_stall got %b want 00", w_stall); else pass_cnt++;
    tick;
  endtask

  // Entered with iptr at 1, so core 1's slot drains ahead of core 0's.
  task automatic test_stall;
    logic [N-1:0]  e_inv, e_st;
    logic [BL-1:0] e_a;
    w_addr[0 +: BL] = 58'h11; w_addr[BL +: BL] = 58'h22; w_wr = 2'b11;
    tick;
    w_addr[0 +: BL] = 58'h77; w_wr = 2'b01;
    e_inv = INV_ON ? 2'b01 : 2'b00; e_a = INV_ON ? 58'h22 : 58'h0; e_st = INV_ON ? 2'b01 : 2'b00;
    total++; if (inv !== e_inv) $display("FAIL stall_inv1 got %b want %b", inv, e_inv); else pass_cnt++;
    total++; if (inv_addr !== e_a) $display("FAIL stall_inv1_addr got %h want %h", inv_addr, e_a); else pass_cnt++;
    total++; if (w_stall !== e_st) $display("FAIL stall_high got %b want %b", w_stall, e_st); else pass_cnt++;
    tick;
    w_wr = 2'b00;
    e_inv = INV_ON ? 2'b10 : 2'b00; e_a = INV_ON ? 58'h11 : 58'h0;
    total++; if (inv !== e_inv) $display("FAIL stall_inv0 got %b want %b", inv, e_inv); else pass_cnt++;
    total++; if (inv_addr !== e_a) $display("FAIL stall_inv0_addr got %h want %h", inv_addr, e_a); else pass_cnt++;
    total++; if (w_stall !== 2'b00) $display("FAIL stall_low got %b want 00", w_stall); else pass_cnt++;
    tick;
    total++; if (inv !== 2'b00) $display("FAIL stall_dropped got %b want 00", inv); else pass_cnt++;
    tick;
  endtask

  task automatic test_taint;
    logic [LN-1:0] d_bad, d_good;
    d_bad  = {16{32'hBAD0_0040}};
    d_good = {16{32'h600D_0040}};
    r_addr[BL +: BL] = 58'h40; r_rd = 2'b10;
    tick;
    total++; if (grant !== 2'b10) $display("FAIL taint_grant got %b want 10", grant); else pass_cnt++;
    total++; if (m_addr !== 58'h40) $display("FAIL taint_m_addr got %h want 40", m_addr); else pass_cnt++;
    w_addr[0 +: BL] = 58'h40; w_wr = 2'b01;
    tick;
    w_wr = 2'b00;
    tick;
    m_dv = 1'b1; m_rdata = d_bad;
    tick;
    m_dv = 1'b0; m_rdata = '0;
`ifdef CMEM_ARB_INV_EN
    total++; if (r_dv !== 2'b00) $display("FAIL taint_no_r_dv got %b want 00", r_dv); else pass_cnt++;
    total++; if (m_rd !== 1'b0) $display("FAIL taint_gap_m_rd got %b want 0", m_rd); else pass_cnt++;
    tick;
    total++; if (m_rd !== 1'b1) $display("FAIL taint_refetch_m_rd got %b want 1", m_rd); else pass_cnt++;
    total++; if (m_addr !== 58'h40) $display("FAIL taint_refetch_addr got %h want 40", m_addr); else pass_cnt++;
    total++; if (grant !== 2'b10) $display("FAIL taint_refetch_grant got %b want 10", grant); else pass_cnt++;
    m_dv = 1'b1; m_rdata = d_good;
    tick;
    m_dv = 1'b0; m_rdata = '0;
    total++; if (r_dv !== 2'b10) $display("FAIL taint_r_dv got %b want 10", r_dv); else pass_cnt++;
    total++; if (r_rdata !== d_good) $display("FAIL taint_r_rdata got %h want %h", r_rdata, d_good); else pass_cnt++;
`else
    total++; if (r_dv !== 2'b10) $display("FAIL notaint_r_dv got %b want 10", r_dv); else pass_cnt++;
    total++; if (r_rdata !== d_bad) $display("FAIL notaint_r_rdata got %h want %h", r_rdata, d_bad); else pass_cnt++;
`endif
    r_rd = 2'b00;
    tick; tick;
  endtask

  task automatic test_reset_mid_fetch;
    r_addr[0 +: BL] = 58'h123; r_rd = 2'b01;
    tick;
    total++; if (m_rd !== 1'b1) $display("FAIL rmf_m_rd_before got %b want 1", m_rd); else pass_cnt++;
    rst = 1'b1;
    tick;
    total++; if (m_rd !== 1'b0) $display("FAIL rmf_m_rd_after got %b want 0", m_rd); else pass_cnt++;
    total++; if (grant !== 2'b00) $display("FAIL rmf_grant got %b want 00", grant); else pass_cnt++;
    rst = 1'b0; r_rd = 2'b00; m_dv = 1'b1; m_rdata = {16{32'hDEAD_BEEF}};
    tick;
    m_dv = 1'b0; m_rdata = '0;
    total++; if (r_dv !== 2'b00) $display("FAIL rmf_r_dv got %b want 00", r_dv); else pass_cnt++;
    tick;
    total++; if (r_dv !== 2'b00) $display("FAIL rmf_r_dv_late got %b want 00", r_dv); else pass_cnt++;
    total++; if (r_rdata !== '0) $display("FAIL rmf_r_rdata got %h want 0", r_rdata); else pass_cnt++;
    total++; if (m_rd !== 1'b0) $display("FAIL rmf_idle_m_rd got %b want 0", m_rd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    test_reset;
    test_single_fill;
    test_contention;
    test_invalidate;
    test_stall;
    test_taint;
    test_reset_mid_fetch;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
